// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO access arbiter.
// Imported by rr_picker and gpio_access_arbiter.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_e;

  localparam int unsigned ARB_LOCK_MAX = 4;
  localparam int unsigned ERR_RDATA    = 0;

endpackage

// File: rtl/gpio_access_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
// Searches upward from ptr_i+1, wrapping modulo NUM_REQ.
module rr_picker
  import gpio_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);

  int          j;
  logic [PW-1:0] jj;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j  = (int'(ptr_i) + i) % NUM_REQ;
      jj = PW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter sharing the GPIO register port, with timeout abort.
// Define GPIO_ARB_LOCK_EN to add lock_i for atomic read-modify-write.
module gpio_access_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  input  logic [NUM_REQ*DW-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  err_o,
  output logic                  gpio_sel_o,
  output logic                  gpio_we_o,
  output logic [AW-1:0]         gpio_addr_o,
  output logic [DW-1:0]         gpio_wdata_o,
`ifdef GPIO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock_i,
`endif
  input  logic                  gpio_ready_i,
  input  logic [DW-1:0]         gpio_rdata_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [PW-1:0]      pick_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win_idx;
  logic               win_any;
  int                 w;

`ifdef GPIO_ARB_LOCK_EN
  localparam int LW = $clog2(ARB_LOCK_MAX) + 1;
  logic          lock_q, lock_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
`endif

  // A held lock makes the previous owner the first candidate.
  always_comb begin
    pick_ptr = ptr_q;
`ifdef GPIO_ARB_LOCK_EN
    if (lock_q) begin
      pick_ptr = (owner_q == '0) ? PW'(NUM_REQ-1)
                                 : owner_q - 1'b1;
    end
`endif
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (pick_ptr),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    w        = int'(win_idx);
`ifdef GPIO_ARB_LOCK_EN
    lock_d   = lock_q;
    lcnt_d   = lcnt_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          gnt_d   = win_oh;
          owner_d = win_idx;
          we_d    = we_i[win_idx];
          addr_d  = addr_i[w*AW +: AW];
          wdata_d = wdata_i[w*DW +: DW];
          sel_d   = 1'b1;
          timer_d = '0;
          state_d = ARB_BUSY;
`ifdef GPIO_ARB_LOCK_EN
          if (win_idx != owner_q) begin
            lcnt_d = '0;
          end
`endif
        end
      end
      ARB_BUSY: begin
        if (gpio_ready_i) begin
          rdata_d  = we_q ? '0 : gpio_rdata_i;
          err_d    = 1'b0;
          sel_d    = 1'b0;
          rvalid_d = NUM_REQ'(1) << owner_q;
          state_d  = ARB_RESP;
        end else if (timer_q == TW'(TIMEOUT_CYC-1)) begin
          rdata_d  = DW'(ERR_RDATA);
          err_d    = 1'b1;
          sel_d    = 1'b0;
          rvalid_d = NUM_REQ'(1) << owner_q;
          state_d  = ARB_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARB_RESP: begin
        ptr_d   = owner_q;
        state_d = ARB_IDLE;
`ifdef GPIO_ARB_LOCK_EN
        lock_d = 1'b0;
        lcnt_d = '0;
        if (lock_i[owner_q] && !err_q &&
            lcnt_q < LW'(ARB_LOCK_MAX-1)) begin
          ptr_d  = ptr_q;
          lock_d = 1'b1;
          lcnt_d = lcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= PW'(NUM_REQ-1);
      owner_q  <= '0;
      timer_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef GPIO_ARB_LOCK_EN
      lock_q   <= 1'b0;
      lcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef GPIO_ARB_LOCK_EN
      lock_q   <= lock_d;
      lcnt_q   <= lcnt_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;
  assign gpio_sel_o   = sel_q;
  assign gpio_we_o    = we_q & sel_q;
  assign gpio_addr_o  = addr_q;
  assign gpio_wdata_o = wdata_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Randomized self-checking bench for gpio_access_arbiter.
// Define GPIO_ARB_LOCK_EN to also exercise lock_i.
module tb_gpio_access_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_i;
  logic [N-1:0]  we_i;
  logic [N*8-1:0]  addr_i;
  logic [N*32-1:0] wdata_i;
  logic [N-1:0]  gnt_o;
  logic [N-1:0]  rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          gpio_sel_o;
  logic          gpio_we_o;
  logic [7:0]    gpio_addr_o;
  logic [31:0]   gpio_wdata_o;
  logic          gpio_ready_i;
  logic [31:0]   gpio_rdata_i;
`ifdef GPIO_ARB_LOCK_EN
  logic [N-1:0]  lock_i = '0;
`endif

  int vectors = 0;
  int miscompares = 0;

  int m_ptr = N-1;
  bit in_resp = 0;

  logic [2:0]  g, rv;
  int          gw, lat, selc;
  logic [31:0] rdo, wdo;
  logic        ero, wo;
  logic [7:0]  ao;

  gpio_access_arbiter #(
    .NUM_REQ     (N),
    .AW          (8),
    .DW          (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .gpio_sel_o   (gpio_sel_o),
    .gpio_we_o    (gpio_we_o),
    .gpio_addr_o  (gpio_addr_o),
    .gpio_wdata_o (gpio_wdata_o),
`ifdef GPIO_ARB_LOCK_EN
    .lock_i       (lock_i),
`endif
    .gpio_ready_i (gpio_ready_i),
    .gpio_rdata_i (gpio_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference: first requester after the pointer, wrapping around.
  function automatic int pick(input logic [2:0] rq);
    for (int i = 1; i <= N; i++) begin
      if (rq[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_i = '0;
    we_i = '0;
    gpio_ready_i = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    m_ptr = N-1;
    in_resp = 0;
  endtask

  task automatic rand_bus();
    for (int r = 0; r < N; r++) begin
      addr_i[r*8 +: 8] = 8'($urandom);
      wdata_i[r*32 +: 32] = $urandom;
    end
  endtask

  // Drives one transaction and reports what was observed.
  task automatic txn(
    input  logic [2:0]  rq,
    input  logic [2:0]  wv,
    input  int          dly,
    input  logic [31:0] rd,
    input  bit          hold,
    output logic [2:0]  og,
    output int          ogw,
    output int          olat,
    output int          osel,
    output logic [2:0]  orv,
    output logic [31:0] ordat,
    output logic        oerr,
    output logic        owe,
    output logic [7:0]  oaddr,
    output logic [31:0] owdat
  );
    req_i = rq;
    we_i = wv;
    ogw = 0;
    og = '0;
    while (og == '0 && ogw < 40) begin
      cyc();
      ogw++;
      og = gnt_o;
    end
    oaddr = gpio_addr_o;
    owdat = gpio_wdata_o;
    owe = gpio_we_o;
    if (!hold) req_i = '0;
    osel = 0;
    olat = 0;
    orv = '0;
    while (orv == '0 && olat < 40) begin
      osel += int'(gpio_sel_o);
      gpio_ready_i = (olat == dly);
      gpio_rdata_i = rd;
      cyc();
      olat++;
      orv = rvalid_o;
    end
    gpio_ready_i = 1'b0;
    ordat = rdata_o;
    oerr = err_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = 3'b111;
    we_i = 3'b111;
    gpio_ready_i = 1'b1;
    rand_bus();
    cyc();
    cyc();
    vectors++;
    if ({gnt_o, rvalid_o, gpio_sel_o, gpio_we_o, err_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctl got %b exp 0",
               {gnt_o, rvalid_o, gpio_sel_o, gpio_we_o, err_o});
    end
    vectors++;
    if ({rdata_o, gpio_addr_o, gpio_wdata_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h exp 0",
               {rdata_o, gpio_addr_o, gpio_wdata_o});
    end
    apply_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      gpio_ready_i = i[0];
      cyc();
      vectors++;
      if ({gnt_o, rvalid_o, gpio_sel_o} !== '0) begin
        miscompares++;
        $display("FAIL idle%0d got %b exp 0", i,
                 {gnt_o, rvalid_o, gpio_sel_o});
      end
    end
    gpio_ready_i = 1'b0;
  endtask

  task automatic test_contention();
    int exp_o[4] = '{0, 1, 2, 0};
    apply_reset();
    rand_bus();
    for (int i = 0; i < 4; i++) begin
      txn(3'b111, 3'b000, 0, 32'h1234_0000 + i, 1,
          g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
      vectors++;
      if (g !== 3'(1 << exp_o[i])) begin
        miscompares++;
        $display("FAIL cont%0d gnt got %b exp %b", i,
                 g, 3'(1 << exp_o[i]));
      end
      vectors++;
      if (gw + lat !== ((i == 0) ? 2 : 3)) begin
        miscompares++;
        $display("FAIL cont%0d spacing got %0d exp %0d",
                 i, gw + lat, (i == 0) ? 2 : 3);
      end
    end
    req_i = '0;
    m_ptr = 0;
    in_resp = 1;
  endtask

  task automatic test_single_read();
    cyc();
    in_resp = 0;
    addr_i[7:0] = 8'h04;
    txn(3'b001, 3'b000, 2, 32'h0000_00A5, 0,
        g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
    vectors++;
    if (g !== 3'b001 || gw !== 1) begin
      miscompares++;
      $display("FAIL rd_gnt got %b/%0d exp 001/1", g, gw);
    end
    vectors++;
    if (ao !== 8'h04 || wo !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_addr got %h/%b exp 04/0", ao, wo);
    end
    vectors++;
    if (selc !== 3 || lat !== 3) begin
      miscompares++;
      $display("FAIL rd_sel got %0d/%0d exp 3/3", selc, lat);
    end
    vectors++;
    if (rv !== 3'b001 || rdo !== 32'hA5 || ero !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_resp got %b/%h/%b exp 001/a5/0",
               rv, rdo, ero);
    end
    m_ptr = 0;
    in_resp = 1;
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    txn(3'b010, 3'b010, -1, 32'hDEAD_BEEF, 0,
        g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
    vectors++;
    if (g !== 3'b010 || lat !== TO) begin
      miscompares++;
      $display("FAIL to_lat got %b/%0d exp 010/%0d", g, lat, TO);
    end
    vectors++;
    if (rv !== 3'b010 || rdo !== 32'h0 || ero !== 1'b1) begin
      miscompares++;
      $display("FAIL to_resp got %b/%h/%b exp 010/0/1",
               rv, rdo, ero);
    end
    cyc();
    vectors++;
    if (err_o !== 1'b1 || rvalid_o !== '0) begin
      miscompares++;
      $display("FAIL to_hold got %b/%b exp 1/000", err_o, rvalid_o);
    end
    in_resp = 0;
    m_ptr = 1;
    rd = $urandom;
    txn(3'b001, 3'b000, 0, rd, 0,
        g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
    vectors++;
    if (g !== 3'b001 || rdo !== rd || ero !== 1'b0 || lat !== 1) begin
      miscompares++;
      $display("FAIL to_next got %b/%h/%b/%0d exp 001/%h/0/1",
               g, rdo, ero, lat, rd);
    end
    m_ptr = 0;
    in_resp = 1;
  endtask

  task automatic test_coincide();
    logic [31:0] rd;
    rd = $urandom;
    txn(3'b100, 3'b000, TO-1, rd, 0,
        g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
    vectors++;
    if (rv !== 3'b100 || ero !== 1'b0 || rdo !== rd || lat !== TO) begin
      miscompares++;
      $display("FAIL coin got %b/%b/%h/%0d exp 100/0/%h/%0d",
               rv, ero, rdo, lat, rd, TO);
    end
    m_ptr = 2;
    in_resp = 1;
  endtask

  task automatic test_reset_busy();
    int seen;
    cyc();
    req_i = 3'b100;
    we_i = 3'b000;
    cyc();
    vectors++;
    if (gnt_o !== 3'b100) begin
      miscompares++;
      $display("FAIL rb_gnt got %b exp 100", gnt_o);
    end
    req_i = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if (gpio_sel_o !== 1'b0 || rvalid_o !== '0) begin
      miscompares++;
      $display("FAIL rb_sel got %b/%b exp 0/000", gpio_sel_o, rvalid_o);
    end
    seen = 0;
    gpio_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (rvalid_o !== '0) seen++;
    end
    gpio_ready_i = 1'b0;
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL rb_rvalid got %0d pulses exp 0", seen);
    end
    m_ptr = N-1;
    in_resp = 0;
    txn(3'b111, 3'b000, 0, 32'h0, 0,
        g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
    vectors++;
    if (g !== 3'b001) begin
      miscompares++;
      $display("FAIL rb_next got %b exp 001", g);
    end
    m_ptr = 0;
    in_resp = 1;
  endtask

`ifdef GPIO_ARB_LOCK_EN
  task automatic test_lock();
    int exp_o[5] = '{0, 0, 0, 0, 1};
    apply_reset();
    lock_i = 3'b001;
    for (int i = 0; i < 5; i++) begin
      txn(3'b011, 3'b000, 0, 32'h0, 1,
          g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
      vectors++;
      if (g !== 3'(1 << exp_o[i])) begin
        miscompares++;
        $display("FAIL lock%0d gnt got %b exp %b", i,
                 g, 3'(1 << exp_o[i]));
      end
    end
    req_i = '0;
    lock_i = '0;
    m_ptr = 1;
    in_resp = 1;
  endtask
`endif

  task automatic test_random();
    logic [2:0]  rq, wv, eoh;
    logic [31:0] rd, ed;
    int          d, r, w, el;
    bit          ee;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        cyc();
        in_resp = 0;
      end
      rq = 3'($urandom_range(1, 7));
      wv = 3'($urandom);
      rand_bus();
      r = $urandom_range(0, 9);
      d = (r <= 5) ? r : (r == 6) ? 14 : (r == 7) ? 15 :
          (r == 8) ? -1 : 16;
      rd = $urandom;
      w = pick(rq);
      eoh = 3'(1 << w);
      ee = !(d >= 0 && d <= TO-1);
      el = ee ? TO : d + 1;
      ed = (ee || wv[w]) ? 32'h0 : rd;
      txn(rq, wv, d, rd, 0,
          g, gw, lat, selc, rv, rdo, ero, wo, ao, wdo);
      vectors++;
      if (g !== eoh || gw !== (in_resp ? 2 : 1)) begin
        miscompares++;
        $display("FAIL rnd%0d gnt got %b/%0d exp %b/%0d",
                 n, g, gw, eoh, in_resp ? 2 : 1);
      end
      vectors++;
      if (ao !== addr_i[w*8 +: 8] || wdo !== wdata_i[w*32 +: 32]
          || wo !== wv[w]) begin
        miscompares++;
        $display("FAIL rnd%0d bus got %h/%h/%b exp %h/%h/%b", n,
                 ao, wdo, wo, addr_i[w*8 +: 8],
                 wdata_i[w*32 +: 32], wv[w]);
      end
      vectors++;
      if (lat !== el || selc !== el) begin
        miscompares++;
        $display("FAIL rnd%0d lat got %0d/%0d exp %0d",
                 n, lat, selc, el);
      end
      vectors++;
      if (rv !== eoh || rdo !== ed || ero !== ee) begin
        miscompares++;
        $display("FAIL rnd%0d resp got %b/%h/%b exp %b/%h/%b",
                 n, rv, rdo, ero, eoh, ed, ee);
      end
      m_ptr = w;
      in_resp = 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0;
    we_i = '0;
    addr_i = '0;
    wdata_i = '0;
    gpio_ready_i = 1'b0;
    gpio_rdata_i = '0;
    test_reset();
    test_idle();
    test_contention();
    test_single_read();
    test_timeout();
    test_coincide();
    test_reset_busy();
`ifdef GPIO_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_access_arbiter.md
Name: gpio_access_arbiter

Overview:
- Round-robin arbiter that shares the single register port of the GPIO block (ports A/B/C) between NUM_REQ bus masters, e.g. core LSU, debug module and UART command bridge.
- Sequences one register transaction at a time: grant, access, wait for ready, return read data.
- Includes a timeout abort so a stalled GPIO port cannot hang the bus.
- Sits between the peripheral interconnect and the GPIO top.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- AW, 8, register address width.
- DW, 32, data width.
- TIMEOUT_CYC, 16, max cycles in BUSY before abort (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_i  in  NUM_REQ  per-requester transaction request; held until gnt_o
- we_i  in  NUM_REQ  per-requester write enable
- addr_i  in  NUM_REQ*AW  flattened addresses; requester r at [r*AW +: AW]
- wdata_i  in  NUM_REQ*DW  flattened write data
- gnt_o  out  NUM_REQ  one-hot one-cycle grant pulse
- rvalid_o  out  NUM_REQ  one-hot one-cycle completion pulse
- rdata_o  out  DW  read data, valid with rvalid_o
- err_o  out  1  timeout error, valid with rvalid_o
- gpio_sel_o  out  1  transaction active on GPIO register port
- gpio_we_o  out  1  write strobe qualifier
- gpio_addr_o  out  AW  latched address
- gpio_wdata_o  out  DW  latched write data
- gpio_ready_i  in  1  GPIO completes the access this cycle
- gpio_rdata_i  in  DW  GPIO read data, valid with gpio_ready_i

Behaviour:
- Reset values (applied at posedge clk while rst=1, from any state including mid-transaction): all outputs 0, state IDLE, rr_ptr = NUM_REQ-1, timer 0. An aborted transaction gets no rvalid_o.
- States: IDLE, BUSY, RESP.
- IDLE: if any req_i, the winner is the first set bit searching from rr_ptr+1 upward, wrapping mod NUM_REQ. At the next edge:
  - gnt_o[w]=1 for one cycle;
  - addr/wdata/we of w are latched into gpio_*_o;
  - gpio_sel_o=1, owner=w, timer=0, go to BUSY.
- Latency: req sampled at edge k gives gnt_o and gpio_sel_o high during cycle k+1.
- Requesters may drop req the cycle after gnt_o.
- BUSY: gpio_sel_o held high and gpio_* outputs stable.
  - gpio_ready_i=1: capture gpio_rdata_i into rdata_o (0 for writes), err_o=0, gpio_sel_o=0, go to RESP.
  - Otherwise timer++. When timer reaches TIMEOUT_CYC-1 with no ready: rdata_o=0, err_o=1, gpio_sel_o=0, go to RESP.
  - If ready and timeout coincide, ready wins.
- RESP: rvalid_o[owner]=1 for exactly one cycle, rr_ptr=owner, go to IDLE. New requests are not granted in RESP.
- Minimum transaction rate: ready in the first BUSY cycle gives IDLE->BUSY->RESP->IDLE, one transaction per 3 cycles.
- rdata_o and err_o hold their values until the next completion.
- No requests: stay in IDLE, outputs idle.
- Simultaneous requests are resolved purely by rr_ptr.
- Fairness: each requester waits at most NUM_REQ-1 transactions.
- gpio_ready_i outside BUSY is ignored.
- Timer width is $clog2(TIMEOUT_CYC)+1 and does not wrap.

Optional Feature:
- Macro GPIO_ARB_LOCK_EN adds input port lock_i[NUM_REQ].
- With macro: if lock_i[owner]=1 in RESP, rr_ptr is left unchanged and owner becomes top priority on the next arbitration, so it wins if still requesting. This enables atomic read-modify-write of reg_dir/reg_out.
  - Lock is ignored after a timeout (err path).
  - A lock held for more than 4 consecutive transactions is forcibly released (rr_ptr=owner).
- Without macro: no lock_i port; pure round-robin.

Decomposition:
- Package gpio_arb_pkg: typedef enum arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESP}; localparam ARB_LOCK_MAX=4; localparam ERR_RDATA='0.
- Sub-module rr_picker: combinational round-robin priority encoder (req vector, pointer -> one-hot winner plus index), parameterised on NUM_REQ.

Test Plan:
- Single read: req_i=3'b001, we=0, addr=8'h04; ready after 2 cycles with rdata=32'h0000_00A5 -> gnt_o[0] at cycle+1, gpio_sel 3 cycles, rvalid_o[0] with rdata_o=32'hA5, err_o=0.
- Contention: req_i=3'b111 held continuously, ready immediately -> grant order 0,1,2,0 at 3-cycle spacing.
- Timeout: req_i[1] write, gpio_ready_i never asserted, TIMEOUT_CYC=16 -> rvalid_o[1] with err_o=1 and rdata_o=0 exactly 16 cycles after grant; next grant proceeds normally.
- Reset mid-BUSY: rst=1 for 1 cycle during req 2 access -> gpio_sel_o=0 next cycle, no rvalid_o, rr_ptr=2 so req 0 wins a subsequent 3'b111.
- Ready/timeout coincidence: gpio_ready_i on timer=TIMEOUT_CYC-1 -> err_o=0, rdata captured.
- Lock (GPIO_ARB_LOCK_EN): req 0 locks while req_i=3'b011 -> 0 granted 4 times consecutively, then 1.
